// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants and classification types for the
// multiplier, accumulator and future adder/divider blocks.
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int SIG_W    = MANT_W + 1;
    localparam int WORD_W   = 1 + EXP_W + MANT_W;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [WORD_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_t;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_NAN,
        SP_INF,
        SP_ZERO
    } fp_special_t;

    // Special-result priority for a product: NaN (incl. inf*0) > inf > zero.
    function automatic fp_special_t resolve_mul_special(input fp_class_t a, input fp_class_t b);
        fp_special_t sp;
        if (a == FP_NAN || b == FP_NAN ||
            (a == FP_INF && b == FP_ZERO) || (a == FP_ZERO && b == FP_INF))
            sp = SP_NAN;
        else if (a == FP_INF || b == FP_INF)
            sp = SP_INF;
        else if (a == FP_ZERO || b == FP_ZERO)
            sp = SP_ZERO;
        else
            sp = SP_NONE;
        return sp;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational split of an IEEE single into sign/exponent/significand plus
// operand class; denormals are flushed and classed as zero.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    output logic              sign_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic [SIG_W-1:0]  sig_o,
    output fp_class_t         cls_o
);

    logic exp_zero;
    logic exp_ones;
    logic frac_zero;

    always_comb begin
        sign_o    = word_i[WORD_W-1];
        exp_o     = word_i[WORD_W-2 -: EXP_W];
        exp_zero  = (exp_o == '0);
        exp_ones  = (exp_o == '1);
        frac_zero = (word_i[MANT_W-1:0] == '0);
        sig_o     = {~exp_zero, word_i[MANT_W-1:0]};
        cls_o     = FP_NORM;
        if (exp_zero)
            cls_o = FP_ZERO;
        else if (exp_ones)
            cls_o = frac_zero ? FP_INF : FP_NAN;
    end

endmodule

// File: rtl/floating_point_multiplier.sv
// Three-stage IEEE single multiplier (unpack / multiply / round+pack) that
// forwards valid/last framing straight into the dot-product accumulator.
module floating_point_multiplier
    import fp_pkg::*;
#(
    parameter  int FRAC_WIDTH = 24,
    parameter  int EXP_WIDTH  = 8,
    localparam int DATA_WIDTH = FRAC_WIDTH + EXP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  validIn,
    input  logic                  lastIn,
    input  logic [DATA_WIDTH-1:0] aIn,
    input  logic [DATA_WIDTH-1:0] bIn,
    output logic                  validOut,
    output logic                  lastOut,
    output logic [DATA_WIDTH-1:0] dataOut
);

    localparam int LATENCY = 3;
    localparam int PROD_W  = 2 * FRAC_WIDTH;
    localparam int EXPW    = EXP_WIDTH + 2;
    localparam int MW      = FRAC_WIDTH - 1;

    localparam logic signed [EXPW-1:0] BIAS_S = EXPW'(EXP_BIAS);
    localparam logic signed [EXPW-1:0] MAX_S  = EXPW'(EXP_MAX);

    logic [LATENCY-1:0] valid_d, valid_q;
    logic [LATENCY-1:0] last_d,  last_q;

    logic                  a_sign, b_sign;
    logic [EXP_WIDTH-1:0]  a_exp,  b_exp;
    logic [FRAC_WIDTH-1:0] a_sig,  b_sig;
    fp_class_t             a_cls,  b_cls;

    logic                  sign1_d, sign1_q;
    logic [EXP_WIDTH-1:0]  ea1_d, ea1_q, eb1_d, eb1_q;
    logic [FRAC_WIDTH-1:0] siga1_d, siga1_q, sigb1_d, sigb1_q;
    fp_class_t             cls_a1_d, cls_a1_q, cls_b1_d, cls_b1_q;

    logic                    sign2_d, sign2_q;
    logic [PROD_W-1:0]       prod2_d, prod2_q;
    logic signed [EXPW-1:0]  exp2_d, exp2_q;
    fp_special_t             sp2_d, sp2_q;

    logic [DATA_WIDTH-1:0] data_d, data_q;

    logic                   guard, sticky, round_up;
    logic [MW-1:0]          mant, mant_f;
    logic [FRAC_WIDTH-1:0]  mant_r;
    logic signed [EXPW-1:0] exp_n, exp_f;
    logic [DATA_WIDTH-1:0]  result;

    fp_unpack u_unpack_a (
        .word_i (aIn),
        .sign_o (a_sign),
        .exp_o  (a_exp),
        .sig_o  (a_sig),
        .cls_o  (a_cls)
    );

    fp_unpack u_unpack_b (
        .word_i (bIn),
        .sign_o (b_sign),
        .exp_o  (b_exp),
        .sig_o  (b_sig),
        .cls_o  (b_cls)
    );

    always_comb begin
        valid_d  = {valid_q[LATENCY-2:0], validIn};
        last_d   = {last_q[LATENCY-2:0], validIn & lastIn};

        sign1_d  = a_sign ^ b_sign;
        ea1_d    = a_exp;
        eb1_d    = b_exp;
        siga1_d  = a_sig;
        sigb1_d  = b_sig;
        cls_a1_d = a_cls;
        cls_b1_d = b_cls;

        // 10-bit signed sum cannot wrap for any pair of 8-bit exponents
        sign2_d  = sign1_q;
        prod2_d  = PROD_W'(siga1_q) * PROD_W'(sigb1_q);
        exp2_d   = $signed({2'b00, ea1_q}) + $signed({2'b00, eb1_q}) - BIAS_S;
        sp2_d    = resolve_mul_special(cls_a1_q, cls_b1_q);
    end

    always_comb begin
        if (prod2_q[PROD_W-1]) begin
            mant   = prod2_q[PROD_W-2 -: MW];
            guard  = prod2_q[FRAC_WIDTH-1];
            sticky = |prod2_q[FRAC_WIDTH-2:0];
            exp_n  = exp2_q + EXPW'(1);
        end else begin
            mant   = prod2_q[PROD_W-3 -: MW];
            guard  = prod2_q[FRAC_WIDTH-2];
            sticky = |prod2_q[FRAC_WIDTH-3:0];
            exp_n  = exp2_q;
        end

        round_up = guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + FRAC_WIDTH'(round_up);
        if (mant_r[FRAC_WIDTH-1]) begin
            mant_f = '0;
            exp_f  = exp_n + EXPW'(1);
        end else begin
            mant_f = mant_r[MW-1:0];
            exp_f  = exp_n;
        end

        case (sp2_q)
            SP_NAN:  result = DATA_WIDTH'(QNAN);
            SP_INF:  result = {sign2_q, {EXP_WIDTH{1'b1}}, {MW{1'b0}}};
            SP_ZERO: result = {sign2_q, {(DATA_WIDTH-1){1'b0}}};
            default: begin
                if (exp_f >= MAX_S)
                    result = {sign2_q, {EXP_WIDTH{1'b1}}, {MW{1'b0}}};
                else if (exp_f[EXPW-1] || exp_f == '0)
                    result = {sign2_q, {(DATA_WIDTH-1){1'b0}}};
                else
                    result = {sign2_q, exp_f[EXP_WIDTH-1:0], mant_f};
            end
        endcase

        data_d = valid_q[LATENCY-2] ? result : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            last_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    // Datapath stages run unconditionally; only the framing flags are reset.
    always_ff @(posedge clk) begin
        sign1_q  <= sign1_d;
        ea1_q    <= ea1_d;
        eb1_q    <= eb1_d;
        siga1_q  <= siga1_d;
        sigb1_q  <= sigb1_d;
        cls_a1_q <= cls_a1_d;
        cls_b1_q <= cls_b1_d;
        sign2_q  <= sign2_d;
        prod2_q  <= prod2_d;
        exp2_q   <= exp2_d;
        sp2_q    <= sp2_d;
    end

    assign validOut = valid_q[LATENCY-1];
    assign lastOut  = last_q[LATENCY-1];
    assign dataOut  = data_q;

endmodule

// File: tb/tb_floating_point_multiplier.sv
// Scoreboard bench for floating_point_multiplier: directed, streaming, framing,
// reset and randomized products checked against an arithmetic reference model.
module tb_floating_point_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        validIn = 1'b0;
    logic        lastIn = 1'b0;
    logic [31:0] aIn = '0;
    logic [31:0] bIn = '0;
    logic        validOut;
    logic        lastOut;
    logic [31:0] dataOut;

    floating_point_multiplier dut (
        .clk      (clk),
        .rst      (rst),
        .validIn  (validIn),
        .lastIn   (lastIn),
        .aIn      (aIn),
        .bIn      (bIn),
        .validOut (validOut),
        .lastOut  (lastOut),
        .dataOut  (dataOut)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          t;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_exp = '0;
    logic        mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact integer product of significands, rounded to nearest-even.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int              ea, eb, e, sh;
        logic            s;
        logic            za, zb, ia, ib, na, nb;
        longint unsigned ma, mb, prod, n, rem, half;
        logic [31:0]     r;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        if (na || nb || (ia && zb) || (ib && za)) return 32'h7FC00000;
        if (ia || ib) return {s, 8'hFF, 23'd0};
        if (za || zb) return {s, 31'd0};
        ma   = 64'h800000 | 64'(a[22:0]);
        mb   = 64'h800000 | 64'(b[22:0]);
        prod = ma * mb;
        e    = ea + eb - 127;
        if (prod >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        n    = prod >> sh;
        rem  = prod - (n << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && n[0])) n = n + 1;
        if (n == (64'd1 << 24)) begin
            n = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        r = {s, 8'(e), n[22:0]};
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        int          k;
        k = int'($urandom_range(0, 9));
        s = 1'($urandom);
        f = 23'($urandom);
        case (k)
            0:       e = 8'd0;
            1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = '0; end
            2:       e = 8'($urandom_range(190, 254));
            3:       e = 8'($urandom_range(1, 64));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {s, e, f};
    endfunction

    task automatic drive(input logic v, input logic l, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] want);
        @(posedge clk);
        #1;
        validIn = v;
        lastIn  = l;
        aIn     = a;
        bIn     = b;
        if (v) sb.push_back('{data: want, last: l, t: cyc});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, $urandom, $urandom, 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (validOut === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 32'(validOut), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("data", dataOut, e.data);
                    check("last", 32'(lastOut), 32'(e.last));
                    check("latency", 32'(cyc - e.t), 32'd3);
                    last_exp = e.data;
                end
            end else begin
                check("valid_idle", 32'(validOut), 32'd0);
                check("last_idle", 32'(lastOut), 32'd0);
                check("hold_data", dataOut, last_exp);
            end
        end
    end

    logic [31:0] dir_a [12] = '{32'h40000000, 32'hC0000000, 32'h3F800001, 32'h3FC00000,
                                32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 32'h80000000,
                                32'h7F800001, 32'hFF800000, 32'h00000001, 32'h80400000};
    logic [31:0] dir_b [12] = '{32'h40400000, 32'h40400000, 32'h3F800001, 32'h3FC00000,
                                32'h40000000, 32'h00800000, 32'h00000000, 32'h40000000,
                                32'h3F800000, 32'h40000000, 32'h7F000000, 32'h40000000};
    logic [31:0] dir_r [12] = '{32'h40C00000, 32'hC0C00000, 32'h3F800002, 32'h40100000,
                                32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h80000000,
                                32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h80000000};
    logic [31:0] stream_a [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        logic        v, l;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid", 32'(validOut), 32'd0);
        check("reset_last", 32'(lastOut), 32'd0);
        check("reset_data", dataOut, 32'd0);
        mon_on = 1'b1;

        // Isolated pulse, then the directed table back-to-back
        drive(1'b1, 1'b0, dir_a[0], dir_b[0], dir_r[0]);
        idle(5);
        for (int i = 0; i < 12; i++) drive(1'b1, (i == 11), dir_a[i], dir_b[i], dir_r[i]);
        idle(5);

        for (int i = 0; i < 8; i++)
            drive(1'b1, (i == 7), stream_a[i], 32'h3F800000, stream_a[i]);
        idle(5);

        for (int i = 0; i < 10; i++) begin
            a = rand_op();
            b = rand_op();
            drive((i % 2 == 0), 1'b1, a, b, ref_mul(a, b));
        end
        idle(5);

        // Reset with two products in flight: both must be dropped
        a = rand_op();
        b = rand_op();
        drive(1'b1, 1'b0, a, b, ref_mul(a, b));
        drive(1'b1, 1'b1, b, a, ref_mul(b, a));
        @(posedge clk);
        #1;
        rst     = 1'b1;
        validIn = 1'b0;
        lastIn  = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        last_exp = '0;
        rst      = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(validOut), 32'd0);
        check("midrst_data", dataOut, 32'd0);
        drive(1'b1, 1'b1, 32'h40000000, 32'h40400000, 32'h40C00000);
        idle(5);

        for (int i = 0; i < 400; i++) begin
            a = rand_op();
            b = rand_op();
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 3) == 0);
            drive(v, l, a, b, ref_mul(a, b));
        end
        idle(6);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        check("drain_pending", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/floating_point_multiplier.md
Name: floating_point_multiplier

Overview:
Pipelined IEEE-754 single-precision multiplier that directly feeds the floating point accumulator (dot-product front end).
- Takes one operand pair per cycle and produces the rounded product.
- Forwards valid/last framing so its outputs connect straight to the accumulator's validIn/lastIn/dataIn.
- Fixed latency, no backpressure; the accumulator accepts every cycle.

Parameters:
FRAC_WIDTH, 24, significand width including hidden bit
EXP_WIDTH, 8, exponent field width
DATA_WIDTH, FRAC_WIDTH+EXP_WIDTH (32), word width; derived, do not override
LATENCY, 3, pipeline depth in cycles; fixed, documented for integrators only

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
validIn  input  1  operand pair valid this cycle
lastIn  input  1  final pair of a vector; meaningful only with validIn=1
aIn  input  DATA_WIDTH  operand A, IEEE single
bIn  input  DATA_WIDTH  operand B, IEEE single
validOut  output  1  product valid (to accumulator validIn)
lastOut  output  1  final product of vector (to accumulator lastIn)
dataOut  output  DATA_WIDTH  product, IEEE single (to accumulator dataIn)

Behaviour:
- Reset: validOut=0, lastOut=0, dataOut=0; all stage valid/last flags cleared; in-flight products discarded. Reset mid-stream drops everything; first post-reset valid output comes 3 cycles after the first post-reset validIn.
- Latency exactly 3 cycles, throughput 1/cycle. validOut(t+3)=validIn(t); lastOut(t+3)=validIn(t)&lastIn(t). dataOut holds its last value when validOut=0.
- Stage 1 (unpack): register sign=a[31]^b[31]. Exponent fields and mantissa with hidden bit. Class flags per operand: zero (exp==0, denormals flushed to zero), inf (exp==255, frac==0), nan (exp==255, frac!=0).
- Stage 2 (multiply): 24x24 -> 48-bit unsigned product. Exponent sum ea+eb-127 in a 10-bit signed width, no wrap. Special-result code resolved here.
- Stage 3 (normalise/round/pack):
  - If prod[47]=1, take mantissa prod[46:24] and exp+1; else prod[45:23].
  - Guard = next bit below LSB; sticky = OR of remaining bits.
  - Round to nearest, ties to even. Rounding carry-out renormalises: mantissa 0, exp+1.
  - Final exp>=255 -> signed infinity. Final exp<=0 -> signed zero (no denormal outputs).
- Special priority (highest first):
  - any NaN, or inf*zero -> canonical quiet NaN 0x7FC00000 (sign ignored)
  - inf*nonzero -> {sign,0xFF,0}
  - zero*finite -> {sign,0x00,0}
  - otherwise the normal path.
- Bubbles (validIn=0) propagate as validOut=0. Arithmetic stages compute unconditionally; only the flags gate.
- lastIn with validIn=0 is ignored and never appears on lastOut.

Decomposition:
- Shared package fp_pkg:
  - EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000
  - field width constants
  - fp_class_t enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN}
  - reused by the accumulator and future adder/divider blocks.
- One sub-module fp_unpack: combinational field split plus classification, instantiated once per operand in stage 1.

Test Plan:
- 0x40000000*0x40400000 (2*3) with validIn pulse at t -> validOut=1 at t+3, dataOut=0x40C00000. 0xC0000000*0x40400000 -> 0xC0C00000.
- Rounding: 0x3F800001*0x3F800001 -> 0x3F800002. 0x3FC00000*0x3FC00000 (1.5^2) -> 0x40100000.
- Boundaries:
  - 0x7F7FFFFF*0x40000000 -> 0x7F800000
  - 0x00800000*0x00800000 -> 0x00000000
  - 0x7F800000*0x00000000 -> 0x7FC00000
  - 0x80000000*0x40000000 -> 0x80000000
- Streaming:
  - Back-to-back pairs a=1.0..8.0, b=1.0, lastIn on the 8th -> eight consecutive validOut cycles, lastOut only on the 8th.
  - With the accumulator chained: accumulator dataOut=0x42100000 (36.0).
- Bubbles/framing:
  - Alternating validIn 1/0 with lastIn held high -> validOut/lastOut alternate identically, delayed by 3.
  - Assert rst for 1 cycle with 2 products in flight -> neither appears; outputs 0 next cycle.
